uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_tx_fifo_drain.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx_fifo_drain : pops bytes from a FIFO read port and serializes them
// LSB-first as start/data/[parity]/stop UART frames.          Rev 1.0
// ============================================================================
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 434,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int c_baud_w = $clog2(BAUD_DIV);
  localparam int c_cnt_w  = $clog2(DATA_WIDTH + 1);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BAUD_DIV - 1);
  localparam logic [c_cnt_w-1:0]  c_data_last = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_cnt_w-1:0]  c_stop_last = c_cnt_w'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_baud_w-1:0]   r_baud;
  logic [c_cnt_w-1:0]    r_bit;
  logic [c_cnt_w-1:0]    w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  r_parity;
  logic                  w_parity_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  w_rd_en;
  logic                  w_done;
  logic                  w_bit_end;

  assign w_bit_end = (r_baud == c_baud_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_rd_en      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty_i) begin
          w_rd_en     = 1'b1;
          w_state_nxt = S_POP;
        end
      end
      S_POP:  w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_shift_nxt  = fifo_rd_data_i;
        w_parity_nxt = (^fifo_rd_data_i) ^ (PARITY_ODD != 0);
        w_state_nxt  = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == c_data_last) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_bit_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit == c_stop_last) begin
            // Chain straight into the next pop to keep back-to-back frames tight
            w_done    = 1'b1;
            w_bit_nxt = '0;
            if (!fifo_empty_i) begin
              w_rd_en     = 1'b1;
              w_state_nxt = S_POP;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is registered from the next state so tx_o is glitch-free
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_tx     <= w_tx_nxt;
      if ((w_state_nxt != r_state) || w_bit_end || (r_state == S_IDLE)) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

  // Gate the pop so a non-empty FIFO is never read while reset is held
  assign fifo_rd_en_o = w_rd_en & ~rst_i;
  assign busy_o       = (r_state != S_IDLE);
  assign frame_done_o = w_done;
  assign tx_o         = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo_drain : directed bench for uart_tx_fifo_drain across four
// parameterisations, each fed by its own FIFO model.          Rev 1.0
// ============================================================================
module tb_uart_tx_fifo_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] empty, rd_en, tx, busy, done;
  logic [7:0] rd_data [4];
  logic [7:0] mem [4][32];
  logic [4:0] wp [4] = '{default: 5'd0};
  logic [4:0] rp [4] = '{default: 5'd0};
  logic [3:0] prev_rd = 4'd0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pop_n  [4] = '{default: 0};
  int done_n [4] = '{default: 0};
  int dbl    [4] = '{default: 0};
  int pop_t  [4][16];

  logic [127:0] cap_tx [4];
  logic [127:0] cap_done [4];
  logic [127:0] cap_busy [4];

  // inst 0: 8N1 baud 4 | inst 1: 8E1 | inst 2: 8O1 | inst 3: 8N2 baud 8
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[0]), .fifo_rd_en_o(rd_en[0]),
    .fifo_rd_data_i(rd_data[0]), .tx_o(tx[0]), .busy_o(busy[0]), .frame_done_o(done[0]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[1]), .fifo_rd_en_o(rd_en[1]),
    .fifo_rd_data_i(rd_data[1]), .tx_o(tx[1]), .busy_o(busy[1]), .frame_done_o(done[1]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[2]), .fifo_rd_en_o(rd_en[2]),
    .fifo_rd_data_i(rd_data[2]), .tx_o(tx[2]), .busy_o(busy[2]), .frame_done_o(done[2]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[3]), .fifo_rd_en_o(rd_en[3]),
    .fifo_rd_data_i(rd_data[3]), .tx_o(tx[3]), .busy_o(busy[3]), .frame_done_o(done[3]));

  for (genvar g = 0; g < 4; g++) begin : g_empty
    assign empty[g] = (wp[g] == rp[g]);
  end

  // FIFO read port model (registered data) plus pop/done bookkeeping
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_rd <= rd_en;
    for (int i = 0; i < 4; i++) begin
      if (rd_en[i]) begin
        rd_data[i]             <= mem[i][rp[i]];
        rp[i]                  <= rp[i] + 5'd1;
        pop_t[i][pop_n[i] % 16] <= cyc;
        pop_n[i]               <= pop_n[i] + 1;
        if (prev_rd[i]) dbl[i] <= dbl[i] + 1;
      end
      if (done[i]) done_n[i] <= done_n[i] + 1;
    end
  end

  task automatic push(input int d, input logic [7:0] b);
    mem[d][wp[d]] = b;
    wp[d] = wp[d] + 5'd1;
  endtask

  task automatic wait_start(input int d, output int lat);
    lat = 0;
    while (tx[d] !== 1'b0 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic capture(input int n);
    for (int d = 0; d < 4; d++) begin
      cap_tx[d] = '0; cap_done[d] = '0; cap_busy[d] = '0;
    end
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 4; d++) begin
        cap_tx[d][i]   = tx[d];
        cap_done[d][i] = done[d];
        cap_busy[d][i] = busy[d];
      end
      @(negedge clk);
    end
  endtask

  // frame bit 0 is the first bit on the line; each bit repeated baud times
  function automatic logic [127:0] expand(input logic [15:0] frame, input int nb, input int baud);
    logic [127:0] v = '0;
    for (int i = 0; i < nb * baud; i++) v[i] = frame[i / baud];
    return v;
  endfunction

  task automatic test_reset;
    int bad = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 4'hF || busy !== 4'h0 || rd_en !== 4'h0 || done !== 4'h0) begin
      fails++;
      $display("FAIL reset_state: tx=%b busy=%b rd_en=%b done=%b, required tx=1111 busy=0000 rd_en=0000 done=0000",
               tx, busy, rd_en, done);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_hold: %0d bad cycles, required 0", bad);
    end
    tests++;
    if (pop_n[0] != 0) begin
      fails++;
      $display("FAIL idle_no_pop: pops=%0d, required 0", pop_n[0]);
    end
  endtask

  task automatic test_single_byte;
    int lat;
    int p0 = pop_n[0];
    int d0 = done_n[0];
    logic [127:0] e;
    logic [39:0] ed;
    push(0, 8'hA5);
    wait_start(0, lat);
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL single_latency: %0d cycles, required 3", lat);
    end
    capture(40);
    e  = expand({1'b1, 8'hA5, 1'b0}, 10, 4);
    ed = 40'd1 << 39;
    tests++;
    if (cap_tx[0][39:0] !== e[39:0]) begin
      fails++;
      $display("FAIL single_tx: got %h, required %h", cap_tx[0][39:0], e[39:0]);
    end
    tests++;
    if (cap_done[0][39:0] !== ed || cap_busy[0][39:0] !== {40{1'b1}}) begin
      fails++;
      $display("FAIL single_done_busy: done=%h busy=%h, required done=%h busy=ffffffffff",
               cap_done[0][39:0], cap_busy[0][39:0], ed);
    end
    tests++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || pop_n[0] - p0 != 1 || done_n[0] - d0 != 1) begin
      fails++;
      $display("FAIL single_end: tx=%b busy=%b pops=%0d dones=%0d, required 1 0 1 1",
               tx[0], busy[0], pop_n[0] - p0, done_n[0] - d0);
    end
  endtask

  task automatic test_parity;
    int lat;
    logic [127:0] ee, eo;
    logic [43:0] ed;
    push(1, 8'h07);
    push(2, 8'h07);
    wait_start(1, lat);
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL parity_latency: %0d cycles, required 3", lat);
    end
    capture(44);
    ee = expand({1'b1, 1'b1, 8'h07, 1'b0}, 11, 4);
    eo = expand({1'b1, 1'b0, 8'h07, 1'b0}, 11, 4);
    ed = 44'd1 << 43;
    tests++;
    if (cap_tx[1][43:0] !== ee[43:0]) begin
      fails++;
      $display("FAIL parity_even_tx: got %h, required %h", cap_tx[1][43:0], ee[43:0]);
    end
    tests++;
    if (cap_tx[2][43:0] !== eo[43:0]) begin
      fails++;
      $display("FAIL parity_odd_tx: got %h, required %h", cap_tx[2][43:0], eo[43:0]);
    end
    tests++;
    if (cap_done[1][43:0] !== ed || busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
      fails++;
      $display("FAIL parity_frame_len: done=%h busy=%b%b, required done=%h busy=00",
               cap_done[1][43:0], busy[1], busy[2], ed);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int p0 = pop_n[0];
    logic [127:0] e1, e2, e3, e, ed, eb;
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    wait_start(0, lat);
    capture(126);
    e1 = expand({1'b1, 8'h00, 1'b0}, 10, 4);
    e2 = expand({1'b1, 8'hFF, 1'b0}, 10, 4);
    e3 = expand({1'b1, 8'h3C, 1'b0}, 10, 4);
    e = '0;
    e[39:0]    = e1[39:0];
    e[41:40]   = 2'b11;
    e[81:42]   = e2[39:0];
    e[83:82]   = 2'b11;
    e[123:84]  = e3[39:0];
    e[125:124] = 2'b11;
    ed = '0;
    ed[39] = 1'b1; ed[81] = 1'b1; ed[123] = 1'b1;
    eb = '0;
    eb[123:0] = {124{1'b1}};
    tests++;
    if (cap_tx[0][125:0] !== e[125:0]) begin
      fails++;
      $display("FAIL b2b_tx: got %h, required %h", cap_tx[0][125:0], e[125:0]);
    end
    tests++;
    if (cap_done[0][125:0] !== ed[125:0] || cap_busy[0][125:0] !== eb[125:0]) begin
      fails++;
      $display("FAIL b2b_done_busy: done=%h busy=%h, required done=%h busy=%h",
               cap_done[0][125:0], cap_busy[0][125:0], ed[125:0], eb[125:0]);
    end
    tests++;
    if (pop_n[0] - p0 != 3 || dbl[0] != 0) begin
      fails++;
      $display("FAIL b2b_pops: pops=%0d double=%0d, required 3 0", pop_n[0] - p0, dbl[0]);
    end
    tests++;
    if (pop_t[0][(p0 + 1) % 16] - pop_t[0][p0 % 16] != 42 ||
        pop_t[0][(p0 + 2) % 16] - pop_t[0][(p0 + 1) % 16] != 42) begin
      fails++;
      $display("FAIL b2b_period: gaps=%0d,%0d, required 42,42",
               pop_t[0][(p0 + 1) % 16] - pop_t[0][p0 % 16],
               pop_t[0][(p0 + 2) % 16] - pop_t[0][(p0 + 1) % 16]);
    end
    tests++;
    if (empty[0] !== 1'b1 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: empty=%b busy=%b, required 1 0", empty[0], busy[0]);
    end
  endtask

  task automatic test_two_stop;
    int lat;
    logic [127:0] e;
    logic [87:0] ed;
    push(3, 8'h55);
    wait_start(3, lat);
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL stop2_latency: %0d cycles, required 3", lat);
    end
    capture(88);
    e  = expand({2'b11, 8'h55, 1'b0}, 11, 8);
    ed = 88'd1 << 87;
    tests++;
    if (cap_tx[3][87:0] !== e[87:0]) begin
      fails++;
      $display("FAIL stop2_tx: got %h, required %h", cap_tx[3][87:0], e[87:0]);
    end
    tests++;
    if (cap_tx[3][87:72] !== 16'hFFFF || cap_done[3][87:0] !== ed || busy[3] !== 1'b0) begin
      fails++;
      $display("FAIL stop2_tail: stop=%h done=%h busy=%b, required stop=ffff done=%h busy=0",
               cap_tx[3][87:72], cap_done[3][87:0], busy[3], ed);
    end
  endtask

  task automatic test_reset_mid_frame;
    int lat;
    int p0 = pop_n[0];
    logic [127:0] e;
    push(0, 8'h12);
    push(0, 8'h34);
    wait_start(0, lat);
    repeat (17) @(negedge clk);
    tests++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: tx=%b busy=%b, required 0 1", tx[0], busy[0]);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: tx=%b busy=%b rd_en=%b, required 1 0 0", tx[0], busy[0], rd_en[0]);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (pop_n[0] - p0 != 1 || empty[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_no_reread: pops=%0d empty=%b, required 1 0", pop_n[0] - p0, empty[0]);
    end
    rst = 1'b0;
    wait_start(0, lat);
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL midrst_latency: %0d cycles, required 3", lat);
    end
    capture(40);
    e = expand({1'b1, 8'h34, 1'b0}, 10, 4);
    tests++;
    if (cap_tx[0][39:0] !== e[39:0] || pop_n[0] - p0 != 2 || empty[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_next_frame: tx=%h pops=%0d empty=%b, required tx=%h pops=2 empty=1",
               cap_tx[0][39:0], pop_n[0] - p0, empty[0], e[39:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
